// File: rtl/mul32_vec_if.sv
// Operand/result handshake bundle between the vector issue stage and the
// mul32 sequencer.
interface mul32_vec_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [1:0]  precision;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    modport master (
        output in_valid, operand_a, operand_b, precision, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, operand_a, operand_b, precision, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mul32_vec_seq_ctrl.sv
// Sequencer that time-shares one 16-bit lane multiplier to build 4x8, 2x16
// or 1x32 unsigned vector products, plus the multiplier itself.
module multiplier_16bit #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  precision,
    output logic [31:0] product
);
    logic [31:0] prod_c;
    logic [31:0] pipe [LATENCY];

    // 00: two independent byte lanes {hi*hi, lo*lo}; otherwise one 16x16
    always_comb begin
        prod_c = 32'(a) * 32'(b);
        if (precision == 2'b00) begin
            prod_c = {16'(16'(a[15:8]) * 16'(b[15:8])),
                      16'(16'(a[7:0])  * 16'(b[7:0]))};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LATENCY); i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= prod_c;
            for (int i = 1; i < int'(LATENCY); i++) pipe[i] <= pipe[i-1];
        end
    end

    assign product = pipe[LATENCY-1];
endmodule

module mul32_vec_seq_ctrl #(
    parameter int unsigned MUL_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    mul32_vec_if.slave   bus
);
    localparam int unsigned PW = 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [31:0]   op_a, op_b;
    logic          wide, lanes8;
    logic [PW-1:0] iss, last_idx;
    logic          iss_en;
    logic          accept, issue;
    logic [15:0]   mul_a, mul_b;
    logic [1:0]    mul_prec;
    logic [31:0]   mul_prod;
    logic [MUL_LATENCY-1:0] pipe_vld;
    logic [PW-1:0] pipe_tag [MUL_LATENCY];
    logic          cap_vld;
    logic [PW-1:0] cap_tag;
    logic [63:0]   cap_term;
    logic [63:0]   acc;
    logic          cap_last;

    multiplier_16bit #(.LATENCY(MUL_LATENCY)) u_mul (
        .clk       (clk),
        .rst_n     (~rst),
        .a         (mul_a),
        .b         (mul_b),
        .precision (mul_prec),
        .product   (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus per-pass operand selection
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        mul_a     = op_a[15:0];
        mul_b     = op_b[15:0];
        mul_prec  = lanes8 ? 2'b00 : 2'b01;
        unique case (state)
            IDLE: if (bus.in_valid) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN:  if (cap_last) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        unique case (iss)
            2'd0: begin mul_a = op_a[15:0];  mul_b = op_b[15:0];  end
            2'd1: begin
                mul_a = wide ? op_a[15:0] : op_a[31:16];
                mul_b = op_b[31:16];
            end
            2'd2: begin mul_a = op_a[31:16]; mul_b = op_b[15:0];  end
            default: begin mul_a = op_a[31:16]; mul_b = op_b[31:16]; end
        endcase
    end

    assign issue    = (state == RUN) && iss_en;
    assign last_idx = wide ? PW'(3) : PW'(1);
    assign cap_vld  = pipe_vld[MUL_LATENCY-1];
    assign cap_tag  = pipe_tag[MUL_LATENCY-1];

    // Partial-product weight for the 32x32 passes: AL*BL, AL*BH, AH*BL, AH*BH
    always_comb begin
        cap_term = 64'(mul_prod);
        if (cap_tag == PW'(3))      cap_term = 64'(mul_prod) << 32;
        else if (cap_tag != PW'(0)) cap_term = 64'(mul_prod) << 16;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.busy      <= 1'b0;
            op_a          <= '0;
            op_b          <= '0;
            wide          <= 1'b0;
            lanes8        <= 1'b0;
            iss           <= '0;
            iss_en        <= 1'b0;
            pipe_vld      <= '0;
            for (int i = 0; i < int'(MUL_LATENCY); i++) pipe_tag[i] <= '0;
            acc           <= '0;
            cap_last      <= 1'b0;
        end else begin
            bus.in_ready  <= (state_nxt == IDLE);
            bus.out_valid <= (state_nxt == DONE);
            bus.busy      <= (state_nxt != IDLE);

            if (accept) begin
                op_a   <= bus.operand_a;
                op_b   <= bus.operand_b;
                wide   <= bus.precision[1];
                lanes8 <= (bus.precision == 2'b00);
                iss    <= '0;
                iss_en <= 1'b1;
            end else if (issue) begin
                iss <= iss + PW'(1);
                if (iss == last_idx) iss_en <= 1'b0;
            end

            // Pass tags travel alongside the multiplier pipeline
            pipe_vld[0] <= issue;
            pipe_tag[0] <= iss;
            for (int i = 1; i < int'(MUL_LATENCY); i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end

            if (accept) begin
                acc <= '0;
            end else if (cap_vld) begin
                if (wide)                 acc         <= acc + cap_term;
                else if (cap_tag[0] == 1'b0) acc[31:0] <= mul_prod;
                else                      acc[63:32]  <= mul_prod;
            end
            cap_last <= cap_vld && (cap_tag == last_idx);

            if ((state == RUN) && cap_last) bus.result <= acc;
        end
    end
endmodule

// File: doc/mul32_vec_seq_ctrl.md
Name: mul32_vec_seq_ctrl

Overview:
- Sequencer that time-shares one internal multiplier_16bit instance to execute 32-bit vector multiplies: four 8x8 lanes, two 16x16 lanes, or one full 32x32.
- Accepts operand pairs over a valid/ready handshake, issues 2 or 4 passes to the multiplier, and assembles or accumulates a 64-bit result.
- Holds the result on a valid/ready output handshake.
- Sits between the vector issue stage and the multiplier datapath.

Parameters:
- MUL_LATENCY, 1: registered latency of the multiplier_16bit instance in cycles. The capture pipeline is aligned with a valid shift register of this depth.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high; all state is cleared on the rising clk edge where rst=1
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept an operand pair
- operand_a  input  32  multiplicand, unsigned
- operand_b  input  32  multiplier, unsigned
- precision  input  2  00 = 4x8-bit lanes; 01 = 2x16-bit lanes; 10 = 32-bit; 11 = treated as 10
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- result  output  64  lane products or full product
- busy  output  1  an operation is in flight (RUN or DONE)

Behaviour:
- Reset values: in_ready=1, out_valid=0, result=0, busy=0; FSM=IDLE; counters cleared.
- The internal multiplier_16bit is clocked by clk, with its active-low reset driven by ~rst.
- Handshake in: on an edge with in_valid && in_ready, latch operand_a, operand_b and precision, then go to RUN.
- in_ready=1 only in IDLE. in_valid is ignored in RUN and DONE.
- Pass count N: 2 for modes 00 and 01; 4 for modes 10 and 11.
- Issue counter iss runs 0..N-1, one pass per cycle, starting the cycle after acceptance.
- Multiplier precision input: 2'b00 in mode 00, otherwise 2'b01.
- Mode 00/01 pass inputs:
  - pass0 = {A[15:0], B[15:0]}, product written to result[31:0]
  - pass1 = {A[31:16], B[31:16]}, product written to result[63:32]
  - Writes overwrite; there is no accumulation.
- Mode 00 lane layout inside each 32-bit half: {hi-byte product, lo-byte product}, each 16 bits.
- Mode 10/11 pass order and shifts:
  - pass0 AL*BL, shift 0
  - pass1 AL*BH, shift 16
  - pass2 AH*BL, shift 16
  - pass3 AH*BH, shift 32
  - A 64-bit accumulator, cleared at acceptance, adds (P << shift). The sum never exceeds 64 bits, so no overflow.
- Capture: a product is consumed MUL_LATENCY cycles after its issue cycle, tagged by a pass-index shift register.
- After the last capture the FSM moves to DONE and out_valid=1. Latency from the acceptance edge to out_valid high is N+MUL_LATENCY+1 cycles: 4 for 2-pass modes, 6 for 4-pass modes (MUL_LATENCY=1).
- DONE: result and out_valid are held stable while out_ready=0. On an edge with out_valid && out_ready, out_valid goes to 0, the FSM returns to IDLE, and in_ready=1 next cycle. There is no back-to-back acceptance in DONE.
- FSM: IDLE -(in handshake)-> RUN -(last capture)-> DONE -(out handshake)-> IDLE.
- rst high in any state: return to IDLE next edge and drop any in-flight operation. No stale capture may leak into the following operation, so the pass shift register is cleared.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Mode 10, a=0xFFFFFFFF, b=0xFFFFFFFF, out_ready=1 -> result=0xFFFFFFFE_00000001, out_valid exactly 6 cycles after acceptance and high for 1 cycle.
- Mode 00, a=0x01020304, b=0x05060708 -> result=0x0005000C_00150020, out_valid 4 cycles after acceptance.
- Mode 01, a=0x1234FFFF, b=0x0002FFFF -> result=0x00002468_FFFE0001.
- Mode 11, a=0x00010000, b=0x00010000 -> result=0x00000001_00000000, 6-cycle latency (identical to mode 10).
- Backpressure: mode 10 op with out_ready=0 for 5 cycles after out_valid rises -> result stable, out_valid=1, in_ready=0, new in_valid ignored. Raising out_ready -> in_ready=1 next cycle.
- Reset mid-op: assert rst for 1 cycle 3 cycles into a mode 10 op -> next cycle out_valid=0, in_ready=1, busy=0. A following mode 01 op with a=0x00030005, b=0x00070002 gives result=0x00000015_0000000A.
